// File: rtl/clock_set_controller_if.sv
// Button, live-time and edit/display signals between the clock-set sequencer and its surroundings.
// Names carry the controller's point of view: i_* flow into it, o_* flow out of it.
interface clock_set_controller_if;
    logic       i_mode_btn;
    logic       i_inc_btn;
    logic [6:0] i_minutes_in;
    logic [5:0] i_hours_in;
    logic [6:0] i_alarm_minutes_in;
    logic [5:0] i_alarm_hours_in;
    logic       o_run_enable;
    logic       o_time_load;
    logic       o_alarm_load;
    logic [6:0] o_edit_minutes;
    logic [5:0] o_edit_hours;
    logic [1:0] o_display_sel;
    logic [1:0] o_field_sel;
    logic       o_blink;

    modport master (
        output i_mode_btn, i_inc_btn, i_minutes_in, i_hours_in,
               i_alarm_minutes_in, i_alarm_hours_in,
        input  o_run_enable, o_time_load, o_alarm_load, o_edit_minutes,
               o_edit_hours, o_display_sel, o_field_sel, o_blink
    );

    modport slave (
        input  i_mode_btn, i_inc_btn, i_minutes_in, i_hours_in,
               i_alarm_minutes_in, i_alarm_hours_in,
        output o_run_enable, o_time_load, o_alarm_load, o_edit_minutes,
               o_edit_hours, o_display_sel, o_field_sel, o_blink
    );
endinterface

// File: rtl/clock_set_controller.sv
// Two-button sequencer for setting the 24-hour clock time and alarm: hours, minutes, load,
// with press auto-repeat, inactivity timeout and a blink phase for the field being edited.
module clock_set_controller #(
    parameter int HOLD_CYCLES    = 25_000_000,
    parameter int REPEAT_CYCLES  = 5_000_000,
    parameter int BLINK_CYCLES   = 12_500_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    clock_set_controller_if.slave bus
);
    localparam int REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int BLK_W   = $clog2(BLINK_CYCLES + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [REP_W-1:0] HOLD_LAST   = REP_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0] REPEAT_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST  = BLK_W'(BLINK_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        RUN, SET_HOURS, SET_MINUTES, COMMIT_TIME,
        ALARM_HOURS, ALARM_MINUTES, COMMIT_ALARM
    } state_t;

    state_t            r_state;
    logic              r_mode_prev;
    logic              r_inc_prev;
    logic [REP_W-1:0]  r_rep_cnt;
    logic              r_rep_phase;
    logic [TO_W-1:0]   r_to_cnt;
    logic [BLK_W-1:0]  r_blink_cnt;
    logic [6:0]        r_edit_minutes;
    logic [5:0]        r_edit_hours;
    logic              r_run_enable;
    logic              r_time_load;
    logic              r_alarm_load;
    logic [1:0]        r_display_sel;
    logic [1:0]        r_field_sel;
    logic              r_blink;

    state_t            w_next_state;
    logic              w_mode_press;
    logic              w_inc_press;
    logic              w_edit;
    logic              w_hours_field;
    logic              w_rep_step;
    logic              w_step_req;
    logic              w_step;
    logic              w_timeout;
    logic              w_state_change;
    logic [5:0]        w_hours_next;
    logic [6:0]        w_minutes_next;

    // Step sources and timeout; a mode press always changes state, so it discards any step.
    always_comb begin
        w_mode_press   = bus.i_mode_btn & ~r_mode_prev;
        w_inc_press    = bus.i_inc_btn & ~r_inc_prev;
        w_edit         = (r_state == SET_HOURS) || (r_state == SET_MINUTES) ||
                         (r_state == ALARM_HOURS) || (r_state == ALARM_MINUTES);
        w_hours_field  = (r_state == SET_HOURS) || (r_state == ALARM_HOURS);
        w_rep_step     = w_edit && bus.i_inc_btn && !w_inc_press &&
                         (r_rep_cnt == (r_rep_phase ? REPEAT_LAST : HOLD_LAST));
        w_step_req     = w_edit && (w_inc_press || w_rep_step);
        w_timeout      = w_edit && !w_mode_press && !w_step_req && (r_to_cnt == TO_LAST);
        w_hours_next   = (r_edit_hours >= 6'd23) ? 6'd0 : r_edit_hours + 6'd1;
        w_minutes_next = (r_edit_minutes >= 7'd59) ? 7'd0 : r_edit_minutes + 7'd1;

        w_next_state = r_state;
        case (r_state)
            RUN:           if (w_mode_press) w_next_state = SET_HOURS;
            SET_HOURS:     if (w_mode_press) w_next_state = SET_MINUTES;
                           else if (w_timeout) w_next_state = RUN;
            SET_MINUTES:   if (w_mode_press) w_next_state = COMMIT_TIME;
                           else if (w_timeout) w_next_state = RUN;
            COMMIT_TIME:   w_next_state = ALARM_HOURS;
            ALARM_HOURS:   if (w_mode_press) w_next_state = ALARM_MINUTES;
                           else if (w_timeout) w_next_state = RUN;
            ALARM_MINUTES: if (w_mode_press) w_next_state = COMMIT_ALARM;
                           else if (w_timeout) w_next_state = RUN;
            COMMIT_ALARM:  w_next_state = RUN;
            default:       w_next_state = RUN;
        endcase

        w_state_change = (w_next_state != r_state);
        w_step         = w_step_req && !w_state_change;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= RUN;
            r_mode_prev    <= 1'b0;
            r_inc_prev     <= 1'b0;
            r_rep_cnt      <= '0;
            r_rep_phase    <= 1'b0;
            r_to_cnt       <= '0;
            r_blink_cnt    <= '0;
            r_edit_minutes <= 7'd0;
            r_edit_hours   <= 6'd0;
            r_run_enable   <= 1'b1;
            r_time_load    <= 1'b0;
            r_alarm_load   <= 1'b0;
            r_display_sel  <= 2'd0;
            r_field_sel    <= 2'd0;
            r_blink        <= 1'b1;
        end else begin
            r_mode_prev <= bus.i_mode_btn;
            r_inc_prev  <= bus.i_inc_btn;
            r_state     <= w_next_state;

            if (!w_edit || w_state_change || !bus.i_inc_btn || w_inc_press) begin
                r_rep_cnt   <= '0;
                r_rep_phase <= 1'b0;
            end else if (w_rep_step) begin
                r_rep_cnt   <= '0;
                r_rep_phase <= 1'b1;
            end else begin
                r_rep_cnt   <= r_rep_cnt + REP_W'(1);
            end

            if (!w_edit || w_state_change || w_step_req)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + TO_W'(1);

            // Alarm values are captured as COMMIT_TIME ends, so edit_* hold steady under time_load.
            if (r_state == RUN && w_next_state == SET_HOURS) begin
                r_edit_hours   <= bus.i_hours_in;
                r_edit_minutes <= bus.i_minutes_in;
            end else if (r_state == COMMIT_TIME) begin
                r_edit_hours   <= bus.i_alarm_hours_in;
                r_edit_minutes <= bus.i_alarm_minutes_in;
            end else if (w_step) begin
                if (w_hours_field)
                    r_edit_hours <= w_hours_next;
                else
                    r_edit_minutes <= w_minutes_next;
            end

            if (w_state_change || !w_edit || w_step) begin
                r_blink     <= 1'b1;
                r_blink_cnt <= '0;
            end else if (r_blink_cnt == BLINK_LAST) begin
                r_blink     <= ~r_blink;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLK_W'(1);
            end

            r_run_enable  <= !(w_next_state == SET_HOURS || w_next_state == SET_MINUTES ||
                               w_next_state == COMMIT_TIME);
            r_time_load   <= (w_next_state == COMMIT_TIME);
            r_alarm_load  <= (w_next_state == COMMIT_ALARM);
            case (w_next_state)
                SET_HOURS, SET_MINUTES, COMMIT_TIME:          r_display_sel <= 2'd1;
                ALARM_HOURS, ALARM_MINUTES, COMMIT_ALARM:     r_display_sel <= 2'd2;
                default:                                      r_display_sel <= 2'd0;
            endcase
            case (w_next_state)
                SET_HOURS, ALARM_HOURS:     r_field_sel <= 2'd1;
                SET_MINUTES, ALARM_MINUTES: r_field_sel <= 2'd2;
                default:                    r_field_sel <= 2'd0;
            endcase
        end
    end

    assign bus.o_run_enable   = r_run_enable;
    assign bus.o_time_load    = r_time_load;
    assign bus.o_alarm_load   = r_alarm_load;
    assign bus.o_edit_minutes = r_edit_minutes;
    assign bus.o_edit_hours   = r_edit_hours;
    assign bus.o_display_sel  = r_display_sel;
    assign bus.o_field_sel    = r_field_sel;
    assign bus.o_blink        = r_blink;
endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with short hold/repeat/blink/timeout periods.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_clock_set_controller;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   timeLoads = 0;
    int   alarmLoads = 0;
    int   bothLoads = 0;
    int   tlBase;
    int   alBase;
    int   repExp [11] = '{58, 58, 58, 58, 59, 59, 0, 0, 1, 1, 1};
    int   blinkExp [7] = '{1, 1, 1, 0, 0, 0, 1};

    clock_set_controller_if bus();

    clock_set_controller #(
        .HOLD_CYCLES(4),
        .REPEAT_CYCLES(2),
        .BLINK_CYCLES(3),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Strobe counting happens mid-cycle so it never races the registered outputs.
    always @(negedge clk) begin
        if (bus.o_time_load) timeLoads++;
        if (bus.o_alarm_load) alarmLoads++;
        if (bus.o_time_load && bus.o_alarm_load) bothLoads++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic mode, input logic inc);
        bus.i_mode_btn = mode;
        bus.i_inc_btn  = inc;
        @(posedge clk);
        #1;
    endtask

    task automatic pressMode();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic pressInc();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.i_mode_btn = 1'b0;
        bus.i_inc_btn  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.i_minutes_in       = 7'd58;
        bus.i_hours_in         = 6'd22;
        bus.i_alarm_minutes_in = 7'd30;
        bus.i_alarm_hours_in   = 6'd7;
        rst = 1'b1;
        bus.i_mode_btn = 1'b0;
        bus.i_inc_btn  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_run_enable", bus.o_run_enable, 1);
        checkOutput("rst_time_load", bus.o_time_load, 0);
        checkOutput("rst_alarm_load", bus.o_alarm_load, 0);
        checkOutput("rst_edit_min", bus.o_edit_minutes, 0);
        checkOutput("rst_edit_hr", bus.o_edit_hours, 0);
        checkOutput("rst_display", bus.o_display_sel, 0);
        checkOutput("rst_field", bus.o_field_sel, 0);
        checkOutput("rst_blink", bus.o_blink, 1);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);

        // Full sequence: 22:58 -> 00:01, alarm 07:30 -> 08:30
        tlBase = timeLoads;
        alBase = alarmLoads;
        applyStimulus(1'b1, 1'b0);
        checkOutput("seq_sethr_display", bus.o_display_sel, 1);
        checkOutput("seq_sethr_field", bus.o_field_sel, 1);
        checkOutput("seq_sethr_run", bus.o_run_enable, 0);
        checkOutput("seq_capture_hr", bus.o_edit_hours, 22);
        checkOutput("seq_capture_min", bus.o_edit_minutes, 58);
        applyStimulus(1'b0, 1'b0);
        pressInc();
        checkOutput("seq_hr_23", bus.o_edit_hours, 23);
        pressInc();
        checkOutput("seq_hr_wrap", bus.o_edit_hours, 0);
        pressMode();
        checkOutput("seq_setmin_field", bus.o_field_sel, 2);
        pressInc();
        pressInc();
        checkOutput("seq_min_wrap", bus.o_edit_minutes, 0);
        pressInc();
        applyStimulus(1'b1, 1'b0);
        checkOutput("seq_time_load", bus.o_time_load, 1);
        checkOutput("seq_commit_hr", bus.o_edit_hours, 0);
        checkOutput("seq_commit_min", bus.o_edit_minutes, 1);
        checkOutput("seq_commit_run", bus.o_run_enable, 0);
        checkOutput("seq_commit_noalarm", bus.o_alarm_load, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("seq_alhr_strobe_off", bus.o_time_load, 0);
        checkOutput("seq_alhr_display", bus.o_display_sel, 2);
        checkOutput("seq_alhr_field", bus.o_field_sel, 1);
        checkOutput("seq_alhr_run", bus.o_run_enable, 1);
        checkOutput("seq_alarm_hr", bus.o_edit_hours, 7);
        checkOutput("seq_alarm_min", bus.o_edit_minutes, 30);
        pressInc();
        checkOutput("seq_alarm_hr_inc", bus.o_edit_hours, 8);
        pressMode();
        checkOutput("seq_almin_field", bus.o_field_sel, 2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("seq_alarm_load", bus.o_alarm_load, 1);
        checkOutput("seq_alarm_load_hr", bus.o_edit_hours, 8);
        checkOutput("seq_alarm_load_min", bus.o_edit_minutes, 30);
        checkOutput("seq_alarm_load_tl", bus.o_time_load, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("seq_back_run_display", bus.o_display_sel, 0);
        checkOutput("seq_back_run_field", bus.o_field_sel, 0);
        checkOutput("seq_back_run_enable", bus.o_run_enable, 1);
        checkOutput("seq_back_run_alarm", bus.o_alarm_load, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("seq_time_load_count", timeLoads - tlBase, 1);
        checkOutput("seq_alarm_load_count", alarmLoads - alBase, 1);

        // Auto-repeat from SET_MINUTES at 57, inc held for 10 cycles
        doReset();
        bus.i_minutes_in = 7'd57;
        pressMode();
        pressMode();
        checkOutput("rep_field", bus.o_field_sel, 2);
        checkOutput("rep_start", bus.o_edit_minutes, 57);
        for (int j = 1; j <= 10; j++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("rep_cycle%0d", j), bus.o_edit_minutes, repExp[j-1]);
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("rep_release", bus.o_edit_minutes, repExp[10]);

        // Simultaneous mode and inc press in SET_HOURS
        doReset();
        bus.i_minutes_in = 7'd58;
        pressMode();
        applyStimulus(1'b1, 1'b1);
        checkOutput("simul_field", bus.o_field_sel, 2);
        checkOutput("simul_hr", bus.o_edit_hours, 22);
        applyStimulus(1'b0, 1'b0);
        checkOutput("simul_hr_after", bus.o_edit_hours, 22);
        checkOutput("simul_min_after", bus.o_edit_minutes, 58);

        // Inactivity timeout out of SET_HOURS
        doReset();
        tlBase = timeLoads;
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 19; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("to_still_edit", bus.o_display_sel, 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("to_display", bus.o_display_sel, 0);
        checkOutput("to_run_enable", bus.o_run_enable, 1);
        checkOutput("to_field", bus.o_field_sel, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("to_no_time_load", timeLoads - tlBase, 0);

        // Blink phase in SET_HOURS, then an inc step forces it visible
        doReset();
        applyStimulus(1'b1, 1'b0);
        checkOutput("blink_c1", bus.o_blink, blinkExp[0]);
        for (int k = 1; k < 7; k++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("blink_c%0d", k + 1), bus.o_blink, blinkExp[k]);
        end
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("blink_low_again", bus.o_blink, 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("blink_step_forced", bus.o_blink, 1);
        checkOutput("blink_step_hr", bus.o_edit_hours, 23);
        applyStimulus(1'b0, 1'b0);
        checkOutput("blink_step_hold", bus.o_blink, 1);

        // Reset asserted during the COMMIT_TIME cycle
        doReset();
        tlBase = timeLoads;
        pressMode();
        pressInc();
        pressMode();
        pressInc();
        applyStimulus(1'b1, 1'b0);
        checkOutput("rstmid_strobe_seen", bus.o_time_load, 1);
        bus.i_mode_btn = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rstmid_time_load", bus.o_time_load, 0);
        checkOutput("rstmid_run_enable", bus.o_run_enable, 1);
        checkOutput("rstmid_display", bus.o_display_sel, 0);
        checkOutput("rstmid_field", bus.o_field_sel, 0);
        checkOutput("rstmid_edit_hr", bus.o_edit_hours, 0);
        checkOutput("rstmid_edit_min", bus.o_edit_minutes, 0);
        checkOutput("rstmid_blink", bus.o_blink, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("rstmid_no_load", timeLoads - tlBase, 0);
        checkOutput("rstmid_after_display", bus.o_display_sel, 0);
        checkOutput("never_both_strobes", bothLoads, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
